dvfs_transition_sequencer: RTL and testbench



---
 rtl/dvfs_transition_sequencer.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_dvfs_transition_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvfs_transition_sequencer.sv
// ---------------------------------------------------------------------------
// dvfs_transition_sequencer
//
// Puts one operating-point change from the power manager onto the regulator
// and PLL controls in a safe order:
//   - On an upscale, the voltage is raised first and allowed to settle.
//     The frequency is raised only after that.
//   - Otherwise, the frequency is lowered first. The voltage is lowered last.
// Downstream clocks are held while the PLL relocks. An unresponsive regulator
// or PLL is abandoned after HS_TIMEOUT cycles.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (accepted only in IDLE)
//   req_volt/req_freq     requested voltage / frequency level codes
//   vreg_req/vreg_volt    regulator change request (level) and target level
//   vreg_ack              regulator reached vreg_volt
//   pll_req/pll_freq      one-cycle PLL retarget pulse and target level
//   pll_lock              PLL lock indicator
//   clk_hold              hold downstream PE clocks during relock
//   cur_volt/cur_freq     committed operating point
//   busy                  transition in progress
//   done                  one-cycle completion pulse
//   err/err_code          one-cycle error pulse
//                         code 1 = illegal point, 2 = PLL timeout,
//                         code 3 = regulator timeout
// ---------------------------------------------------------------------------
module dvfs_transition_sequencer #(
    parameter int LVL_W          = 3,
    parameter int VSETTLE_CYCLES = 16,
    parameter int HS_TIMEOUT     = 255,
    parameter int RESET_VOLT     = 1,
    parameter int RESET_FREQ     = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [LVL_W-1:0] req_volt,
    input  logic [LVL_W-1:0] req_freq,
    output logic             vreg_req,
    output logic [LVL_W-1:0] vreg_volt,
    input  logic             vreg_ack,
    output logic             pll_req,
    output logic [LVL_W-1:0] pll_freq,
    input  logic             pll_lock,
    output logic             clk_hold,
    output logic [LVL_W-1:0] cur_volt,
    output logic [LVL_W-1:0] cur_freq,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        V_CHG    = 3'd1,
        V_SETTLE = 3'd2,
        F_CHG    = 3'd3,
        F_WAITLO = 3'd4,
        F_WAITHI = 3'd5,
        DONE     = 3'd6,
        ERR      = 3'd7
    } state_t;

    localparam logic [LVL_W-1:0] RST_VOLT     = LVL_W'(RESET_VOLT);
    localparam logic [LVL_W-1:0] RST_FREQ     = LVL_W'(RESET_FREQ);
    localparam logic [7:0]       SETTLE_LOAD  = 8'(VSETTLE_CYCLES);
    localparam logic [7:0]       TIMEOUT_LOAD = 8'(HS_TIMEOUT);
    localparam logic [1:0]       ERR_ILLEGAL  = 2'd1;
    localparam logic [1:0]       ERR_PLL      = 2'd2;
    localparam logic [1:0]       ERR_VREG     = 2'd3;

    state_t           state_r;
    logic             req_ready_r;
    logic             vreg_req_r;
    logic [LVL_W-1:0] vreg_volt_r;
    logic             pll_req_r;
    logic [LVL_W-1:0] pll_freq_r;
    logic             clk_hold_r;
    logic [LVL_W-1:0] cur_volt_r;
    logic [LVL_W-1:0] cur_freq_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic [1:0]       err_code_r;
    logic [LVL_W-1:0] tgt_volt_r;
    logic [LVL_W-1:0] tgt_freq_r;
    // Shared by the settle delay and every handshake timeout.
    logic [7:0]       cnt_r;

    // Transition FSM; every output is registered here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b1;
            vreg_req_r  <= 1'b0;
            vreg_volt_r <= RST_VOLT;
            pll_req_r   <= 1'b0;
            pll_freq_r  <= RST_FREQ;
            clk_hold_r  <= 1'b0;
            cur_volt_r  <= RST_VOLT;
            cur_freq_r  <= RST_FREQ;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            err_code_r  <= 2'd0;
            tgt_volt_r  <= RST_VOLT;
            tgt_freq_r  <= RST_FREQ;
            cnt_r       <= 8'd0;
        end else begin
            // Pulse outputs last a single cycle unless a branch below re-arms them.
            pll_req_r  <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            err_code_r <= 2'd0;

            case (state_r)
                IDLE: begin
                    if (req_valid && req_ready_r) begin
                        if (req_freq > req_volt) begin
                            // Rejected in place: the state does not change and no control output moves.
                            err_r      <= 1'b1;
                            err_code_r <= ERR_ILLEGAL;
                        end else begin
                            tgt_volt_r  <= req_volt;
                            tgt_freq_r  <= req_freq;
                            req_ready_r <= 1'b0;
                            if (req_volt > cur_volt_r) begin
                                // Upscale: raise the voltage before touching the PLL.
                                state_r     <= V_CHG;
                                vreg_req_r  <= 1'b1;
                                vreg_volt_r <= req_volt;
                                cnt_r       <= TIMEOUT_LOAD;
                                busy_r      <= 1'b1;
                            end else if (req_freq != cur_freq_r) begin
                                // Frequency moves first when the voltage is not rising.
                                state_r    <= F_CHG;
                                pll_req_r  <= 1'b1;
                                pll_freq_r <= req_freq;
                                clk_hold_r <= 1'b1;
                                busy_r     <= 1'b1;
                            end else if (req_volt < cur_volt_r) begin
                                state_r     <= V_CHG;
                                vreg_req_r  <= 1'b1;
                                vreg_volt_r <= req_volt;
                                cnt_r       <= TIMEOUT_LOAD;
                                busy_r      <= 1'b1;
                            end else begin
                                state_r <= DONE;
                                done_r  <= 1'b1;
                                busy_r  <= 1'b0;
                            end
                        end
                    end
                end

                V_CHG: begin
                    if (vreg_ack) begin
                        vreg_req_r <= 1'b0;
                        cur_volt_r <= tgt_volt_r;
                        state_r    <= V_SETTLE;
                        cnt_r      <= SETTLE_LOAD;
                    end else if (cnt_r == 8'd1) begin
                        // The regulator never answered. Drop the request and point it back at the committed level.
                        vreg_req_r  <= 1'b0;
                        vreg_volt_r <= cur_volt_r;
                        state_r     <= ERR;
                        err_r       <= 1'b1;
                        err_code_r  <= ERR_VREG;
                        busy_r      <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end

                V_SETTLE: begin
                    if (cnt_r == 8'd1) begin
                        // A frequency step can still be pending only on the upscale path.
                        if (tgt_freq_r != cur_freq_r) begin
                            state_r    <= F_CHG;
                            pll_req_r  <= 1'b1;
                            pll_freq_r <= tgt_freq_r;
                            clk_hold_r <= 1'b1;
                        end else begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end

                F_CHG: begin
                    // The timeout spans both lock phases, so the counter is loaded once, here.
                    state_r <= F_WAITLO;
                    cnt_r   <= TIMEOUT_LOAD;
                end

                F_WAITLO: begin
                    // A lock that is still high belongs to the old frequency, so wait for it to drop first.
                    if (cnt_r == 8'd1) begin
                        state_r    <= ERR;
                        pll_freq_r <= cur_freq_r;
                        clk_hold_r <= 1'b0;
                        err_r      <= 1'b1;
                        err_code_r <= ERR_PLL;
                        busy_r     <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                        if (!pll_lock) begin
                            state_r <= F_WAITHI;
                        end
                    end
                end

                F_WAITHI: begin
                    if (pll_lock) begin
                        cur_freq_r <= tgt_freq_r;
                        clk_hold_r <= 1'b0;
                        if (tgt_volt_r < cur_volt_r) begin
                            state_r     <= V_CHG;
                            vreg_req_r  <= 1'b1;
                            vreg_volt_r <= tgt_volt_r;
                            cnt_r       <= TIMEOUT_LOAD;
                        end else begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                        end
                    end else if (cnt_r == 8'd1) begin
                        // Abandon the step. A pending voltage-down step is dropped. A voltage already raised stays raised.
                        state_r    <= ERR;
                        pll_freq_r <= cur_freq_r;
                        clk_hold_r <= 1'b0;
                        err_r      <= 1'b1;
                        err_code_r <= ERR_PLL;
                        busy_r     <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end

                DONE: begin
                    state_r     <= IDLE;
                    req_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                end

                ERR: begin
                    state_r     <= IDLE;
                    req_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                end

                default: begin
                    // Unreachable encoding. Return to a quiet IDLE on the committed point.
                    state_r     <= IDLE;
                    req_ready_r <= 1'b1;
                    vreg_req_r  <= 1'b0;
                    vreg_volt_r <= cur_volt_r;
                    pll_freq_r  <= cur_freq_r;
                    clk_hold_r  <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign vreg_req  = vreg_req_r;
    assign vreg_volt = vreg_volt_r;
    assign pll_req   = pll_req_r;
    assign pll_freq  = pll_freq_r;
    assign clk_hold  = clk_hold_r;
    assign cur_volt  = cur_volt_r;
    assign cur_freq  = cur_freq_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign err_code  = err_code_r;

endmodule

// File: tb/tb_dvfs_transition_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dvfs_transition_sequencer
//
// Directed bench for dvfs_transition_sequencer.
// - A table of requests is applied in order from the reset point. The regulator
//   acks 2 cycles after vreg_req. The PLL drops lock 3 cycles after pll_req and
//   raises it 5 cycles later.
// - Hand-written sequences then cover the regulator timeout, the PLL timeout
//   and an asynchronous reset in the middle of a transition.
// Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_dvfs_transition_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] req_volt = 3'd0;
    logic [2:0] req_freq = 3'd0;
    logic       vreg_req;
    logic [2:0] vreg_volt;
    logic       vreg_ack = 1'b0;
    logic       pll_req;
    logic [2:0] pll_freq;
    logic       pll_lock = 1'b1;
    logic       clk_hold;
    logic [2:0] cur_volt;
    logic [2:0] cur_freq;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    always #5 clk = ~clk;

    dvfs_transition_sequencer #(
        .LVL_W(3), .VSETTLE_CYCLES(16), .HS_TIMEOUT(255), .RESET_VOLT(1), .RESET_FREQ(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_volt(req_volt), .req_freq(req_freq), .vreg_req(vreg_req), .vreg_volt(vreg_volt),
        .vreg_ack(vreg_ack), .pll_req(pll_req), .pll_freq(pll_freq), .pll_lock(pll_lock),
        .clk_hold(clk_hold), .cur_volt(cur_volt), .cur_freq(cur_freq), .busy(busy),
        .done(done), .err(err), .err_code(err_code)
    );

    typedef struct {
        int volt, freq;
        int exp_err, exp_code, exp_cv, exp_cf;
        int exp_vreg, exp_pll, exp_order;   // order: 0 none, 1 vreg first, 2 pll first
        int exp_ready_end, exp_lat, chk_settle, exp_pf, exp_vv;
    } vec_t;

    int tests = 0;
    int fails = 0;

    // Per-transaction observations, filled in by step()
    int cyc_n = 0;
    int acc_cyc, end_cyc, ack_cyc, first_vreg, first_pll;
    int vreg_rise, vreg_hi, pll_cnt, hold_cycles, done_cnt, err_cnt, code_seen, inv_viol;
    int pf_at_pll, vv_at_pll, vv_at_end, vreq_at_end, pf_at_end, hold_at_end, ready_at_end;
    int vreg_age = 0;
    int pll_t = 1000;
    bit vreg_prev = 1'b0;
    bit vreg_mode = 1'b1;    // 1: regulator acks, 0: never acks
    bit pll_mode = 1'b1;     // 1: PLL relocks, 0: lock stuck high

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear_obs();
        end_cyc = -1; ack_cyc = -1; first_vreg = -1; first_pll = -1;
        vreg_rise = 0; vreg_hi = 0; pll_cnt = 0; hold_cycles = 0;
        done_cnt = 0; err_cnt = 0; code_seen = 0; inv_viol = 0;
        pf_at_pll = -1; vv_at_pll = -1; vv_at_end = -1; vreq_at_end = -1;
        pf_at_end = -1; hold_at_end = -1; ready_at_end = -1;
    endtask

    // One cycle: sample outputs at the falling edge, then drive the regulator/PLL models.
    task automatic step();
        @(negedge clk);
        if (cur_freq > cur_volt || pll_freq > vreg_volt) inv_viol++;
        if (vreg_req && !vreg_prev) begin
            vreg_rise++;
            if (first_vreg < 0) first_vreg = cyc_n;
        end
        vreg_prev = vreg_req;
        if (vreg_req) vreg_hi++;
        if (pll_req) begin
            pll_cnt++;
            if (first_pll < 0) begin
                first_pll = cyc_n;
                pf_at_pll = int'(pll_freq);
                vv_at_pll = int'(vreg_volt);
            end
        end
        if (clk_hold) hold_cycles++;
        if (done) done_cnt++;
        if (err) begin
            err_cnt++;
            code_seen = int'(err_code);
        end
        if ((done || err) && end_cyc < 0) begin
            end_cyc      = cyc_n;
            vv_at_end    = int'(vreg_volt);
            vreq_at_end  = int'(vreg_req);
            pf_at_end    = int'(pll_freq);
            hold_at_end  = int'(clk_hold);
            ready_at_end = int'(req_ready);
        end
        // Regulator: ack from the third cycle of vreg_req onwards
        if (vreg_mode && vreg_req) vreg_age++;
        else vreg_age = 0;
        vreg_ack = vreg_mode && vreg_req && (vreg_age >= 3);
        if (vreg_ack && ack_cyc < 0) ack_cyc = cyc_n;
        // PLL: lock low for t = 3..7 after the pll_req cycle
        if (pll_req) pll_t = 0;
        else if (pll_t < 1000) pll_t++;
        pll_lock = pll_mode ? !(pll_t >= 3 && pll_t <= 7) : 1'b1;
        cyc_n++;
    endtask

    task automatic run_request(input int v, input int f, input string nm);
        int n;
        clear_obs();
        n = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        req_volt  = 3'(v);
        req_freq  = 3'(f);
        req_valid = 1'b1;
        acc_cyc   = cyc_n - 1;
        step();
        req_valid = 1'b0;
        n = 0;
        while (end_cyc < 0 && n < 3000) begin
            step();
            n++;
        end
        chk({nm, " completes"}, int'(end_cyc >= 0), 1);
        step();
        chk({nm, " ready after end"}, int'(req_ready), 1);
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, " cur_volt"}, int'(cur_volt), 1);
        chk({nm, " cur_freq"}, int'(cur_freq), 1);
        chk({nm, " vreg_volt"}, int'(vreg_volt), 1);
        chk({nm, " pll_freq"}, int'(pll_freq), 1);
        chk({nm, " ctl bits"}, int'({vreg_req, pll_req, clk_hold, busy, done, err}), 0);
        chk({nm, " err_code"}, int'(err_code), 0);
        chk({nm, " req_ready"}, int'(req_ready), 1);
    endtask

    function automatic vec_t mk(int v, int f, int e, int c, int cv, int cf, int nv, int np,
                                int ord, int rdy, int lat, int st, int pf, int vv);
        vec_t r;
        r.volt = v; r.freq = f; r.exp_err = e; r.exp_code = c; r.exp_cv = cv; r.exp_cf = cf;
        r.exp_vreg = nv; r.exp_pll = np; r.exp_order = ord; r.exp_ready_end = rdy;
        r.exp_lat = lat; r.chk_settle = st; r.exp_pf = pf; r.exp_vv = vv;
        return r;
    endfunction

    vec_t vecs[8];

    initial begin
        string nm;
        int order;

        //               v  f  e  c cv cf nv np ord rdy lat st  pf  vv
        vecs[0] = mk(3, 3, 0, 0, 3, 3, 1, 1, 1, 0, -1, 1, -1, -1); // upscale 1/1 -> 3/3
        vecs[1] = mk(3, 3, 0, 0, 3, 3, 0, 0, 0, 0,  1, 0, -1, -1); // same point
        vecs[2] = mk(1, 1, 0, 0, 1, 1, 1, 1, 2, 0, -1, 0,  1,  3); // downscale 3/3 -> 1/1
        vecs[3] = mk(1, 2, 1, 1, 1, 1, 0, 0, 0, 1,  1, 0, -1, -1); // illegal freq > volt
        vecs[4] = mk(2, 1, 0, 0, 2, 1, 1, 0, 1, 0, -1, 0, -1, -1); // voltage up only
        vecs[5] = mk(2, 2, 0, 0, 2, 2, 0, 1, 2, 0, -1, 0, -1, -1); // frequency up only
        vecs[6] = mk(3, 1, 0, 0, 3, 1, 1, 1, 1, 0, -1, 1, -1, -1); // volt up, freq down
        vecs[7] = mk(1, 1, 0, 0, 1, 1, 1, 0, 1, 0, -1, 0, -1, -1); // voltage down only

        clear_obs();
        repeat (3) step();
        check_reset_vals("reset");
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            nm = $sformatf("vec%0d", i);
            run_request(vecs[i].volt, vecs[i].freq, nm);
            chk({nm, " err pulses"}, err_cnt, vecs[i].exp_err);
            chk({nm, " done pulses"}, done_cnt, 1 - vecs[i].exp_err);
            chk({nm, " err_code"}, code_seen, vecs[i].exp_code);
            chk({nm, " cur_volt"}, int'(cur_volt), vecs[i].exp_cv);
            chk({nm, " cur_freq"}, int'(cur_freq), vecs[i].exp_cf);
            chk({nm, " vreg_req count"}, vreg_rise, vecs[i].exp_vreg);
            chk({nm, " pll_req count"}, pll_cnt, vecs[i].exp_pll);
            if (first_vreg < 0 && first_pll < 0) order = 0;
            else if (first_pll < 0 || (first_vreg >= 0 && first_vreg < first_pll)) order = 1;
            else order = 2;
            chk({nm, " step order"}, order, vecs[i].exp_order);
            chk({nm, " clk_hold cycles"}, hold_cycles, 9 * vecs[i].exp_pll);
            chk({nm, " invariant"}, inv_viol, 0);
            chk({nm, " req_ready at end"}, ready_at_end, vecs[i].exp_ready_end);
            if (vecs[i].exp_lat >= 0) chk({nm, " end latency"}, end_cyc - acc_cyc, vecs[i].exp_lat);
            if (vecs[i].chk_settle != 0) chk({nm, " settle cycles"}, first_pll - ack_cyc - 1, 16);
            if (vecs[i].exp_pf >= 0) begin
                chk({nm, " pll_freq at pll_req"}, pf_at_pll, vecs[i].exp_pf);
                chk({nm, " vreg_volt at pll_req"}, vv_at_pll, vecs[i].exp_vv);
            end
        end

        // Regulator never acks: 1/1 -> 2/1
        vreg_mode = 1'b0;
        run_request(2, 1, "vreg_to");
        chk("vreg_to err_code", code_seen, 3);
        chk("vreg_to vreg_req cycles", vreg_hi, 255);
        chk("vreg_to err latency", end_cyc - first_vreg, 255);
        chk("vreg_to vreg_volt", vv_at_end, 1);
        chk("vreg_to vreg_req", vreq_at_end, 0);
        chk("vreg_to cur_volt", int'(cur_volt), 1);
        vreg_mode = 1'b1;

        // PLL lock stuck high: 1/1 -> 3/3
        pll_mode = 1'b0;
        run_request(3, 3, "pll_to");
        chk("pll_to err_code", code_seen, 2);
        chk("pll_to err latency", end_cyc - first_pll, 256);
        chk("pll_to pll_freq", pf_at_end, 1);
        chk("pll_to clk_hold", hold_at_end, 0);
        chk("pll_to cur_volt", int'(cur_volt), 3);
        chk("pll_to cur_freq", int'(cur_freq), 1);
        chk("pll_to invariant", inv_viol, 0);

        // Asynchronous reset while waiting in F_WAITLO (3/1 -> 3/3, lock stuck high)
        clear_obs();
        req_volt  = 3'd3;
        req_freq  = 3'd3;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (3) step();
        chk("mid busy", int'(busy), 1);
        chk("mid clk_hold", int'(clk_hold), 1);
        #2 reset_n = 1'b0;
        #1 check_reset_vals("async reset");
        repeat (2) step();
        reset_n  = 1'b1;
        pll_mode = 1'b1;
        step();
        run_request(2, 2, "post_reset");
        chk("post_reset done", done_cnt, 1);
        chk("post_reset cur_volt", int'(cur_volt), 2);
        chk("post_reset cur_freq", int'(cur_freq), 2);
        chk("post_reset vreg_req count", vreg_rise, 1);
        chk("post_reset pll_req count", pll_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
